// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan controller:
//   state_e     - scan FSM states (blanking gap / digit lit)
//   SEG_OFF     - active-low segment pattern with every segment dark
//   cnt_width() - bit width needed to count 0..n-1 (never less than 1)
// -----------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex2seg.sv
// -----------------------------------------------------------------------------
// hex2seg
// Hex nibble to seven-segment decoder, active-low outputs.
// Bit order is {a,b,c,d,e,f,g}: bit 6 = segment a, bit 0 = segment g.
// Ports:
//   hex_i [3:0]  nibble to display
//   seg_o [6:0]  segment lines, 0 = lit
// -----------------------------------------------------------------------------
module hex2seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        case (hex_i)
            4'h0: seg_o = 7'b0000001;
            4'h1: seg_o = 7'b1001111;
            4'h2: seg_o = 7'b0010010;
            4'h3: seg_o = 7'b0000110;
            4'h4: seg_o = 7'b1001100;
            4'h5: seg_o = 7'b0100100;
            4'h6: seg_o = 7'b0100000;
            4'h7: seg_o = 7'b0001111;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0000100;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b1100000;
            4'hC: seg_o = 7'b0110001;
            4'hD: seg_o = 7'b1000010;
            4'hE: seg_o = 7'b0110000;
            4'hF: seg_o = 7'b0111000;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scan controller for DIGITS common-anode seven-segment
// digits sharing one hex2seg decoder. Each digit slot is BLANK_CYC cycles with
// all anodes off followed by ON_CYC cycles lit. New data is double-buffered and
// only committed on the last SHOW cycle of the last digit, so a frame never
// mixes old and new data.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   load           one-cycle request to take data_in/dp_in/en_mask
//   data_in        hex nibbles, digit i at [4i+3:4i], digit 0 scanned first
//   dp_in          decimal point request per digit (1 = lit)
//   en_mask        digit enable (0 = anode stays off for its slot)
//   segs, dp       active-low segment lines and decimal point (registered)
//   an             active-low anode enables (registered, one-cold at most)
//   ack            pulse in the cycle the active buffer is committed
// -----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int ON_CYC    = 50000,
    parameter int BLANK_CYC = 2500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_mask,
    output logic [6:0]            segs,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  ack
);

    localparam int CW = cnt_width((ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(DIGITS - 1);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [2:0]               idx_q, idx_d;
    logic                     commit;

    logic [DIGITS-1:0][3:0]   act_data_q, act_data_d;
    logic [DIGITS-1:0]        act_dp_q, act_dp_d;
    logic [DIGITS-1:0]        act_mask_q, act_mask_d;
    logic [DIGITS-1:0][3:0]   pnd_data_q, pnd_data_d;
    logic [DIGITS-1:0]        pnd_dp_q, pnd_dp_d;
    logic [DIGITS-1:0]        pnd_mask_q, pnd_mask_d;
    logic                     pend_q, pend_d;

    logic [6:0]               segs_q, segs_d;
    logic                     dp_q, dp_d;
    logic [DIGITS-1:0]        an_q, an_d;

    logic [IW-1:0]            lit_idx;
    logic                     lit_d;
    logic [3:0]               dec_in;
    logic [6:0]               dec_seg;

    // ---------------- scan FSM ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        commit  = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == ON_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        commit = 1'b1;   // frame boundary
                    end else begin
                        idx_d  = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- frame buffers ----------------
    // A load in the commit cycle goes straight to the active buffer so the
    // newest data wins and no stale pending copy is left behind.
    always_comb begin
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        act_mask_d = act_mask_q;
        pnd_data_d = pnd_data_q;
        pnd_dp_d   = pnd_dp_q;
        pnd_mask_d = pnd_mask_q;
        pend_d     = pend_q;
        if (load) begin
            pnd_data_d = data_in;
            pnd_dp_d   = dp_in;
            pnd_mask_d = en_mask;
            pend_d     = 1'b1;
        end
        if (commit) begin
            if (load) begin
                act_data_d = data_in;
                act_dp_d   = dp_in;
                act_mask_d = en_mask;
                pend_d     = 1'b0;
            end else if (pend_q) begin
                act_data_d = pnd_data_q;
                act_dp_d   = pnd_dp_q;
                act_mask_d = pnd_mask_q;
                pend_d     = 1'b0;
            end
        end
    end

    assign ack = !rst && commit && (load || pend_q);

    // ---------------- output decode ----------------
    // Outputs are computed from next-state so segs/dp/an move on the same
    // edge as the FSM. At commit the next state is BLANK, so reading the
    // active buffer's current value is safe.
    assign lit_idx = idx_d[IW-1:0];
    assign dec_in  = act_data_q[lit_idx];
    assign lit_d   = (state_d == ST_SHOW) && act_mask_q[lit_idx];

    hex2seg u_dec (
        .hex_i (dec_in),
        .seg_o (dec_seg)
    );

    always_comb begin
        segs_d = lit_d ? dec_seg : SEG_OFF;
        dp_d   = !(lit_d && act_dp_q[lit_idx]);
        an_d   = lit_d ? ~(DIGITS'(1) << lit_idx) : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            idx_q      <= '0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            act_mask_q <= '0;
            pnd_data_q <= '0;
            pnd_dp_q   <= '0;
            pnd_mask_q <= '0;
            pend_q     <= 1'b0;
            segs_q     <= SEG_OFF;
            dp_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            act_mask_q <= act_mask_d;
            pnd_data_q <= pnd_data_d;
            pnd_dp_q   <= pnd_dp_d;
            pnd_mask_q <= pnd_mask_d;
            pend_q     <= pend_d;
            segs_q     <= segs_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign segs = segs_q;
    assign dp   = dp_q;
    assign an   = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIGITS=4, ON_CYC=4, BLANK_CYC=1 (20-cycle frame).
// Loads are pushed to a scoreboard; an expected commit pops the entry into the
// displayed buffer, and each cycle's outputs are compared with the frame slot.
module tb_seg_scan_ctrl;

    localparam int FRAME = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  en_mask;
    logic [6:0]  segs;
    logic        dp;
    logic [3:0]  an;
    logic        ack;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(4), .ON_CYC(4), .BLANK_CYC(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .dp_in   (dp_in),
        .en_mask (en_mask),
        .segs    (segs),
        .dp      (dp),
        .an      (an),
        .ack     (ack)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dpm;
        logic [3:0]  mask;
    } buf_t;

    buf_t sb[$];
    buf_t disp;
    int   pos;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // Expected {an, segs, dp} for frame slot pos (4 lit + 1 blank per digit).
    function automatic logic [11:0] exp_out();
        int d;
        logic [3:0] one;
        if (pos % 5 == 4) return {4'hF, 7'h7F, 1'b1};
        d = pos / 5;
        if (!disp.mask[d]) return {4'hF, 7'h7F, 1'b1};
        one = 4'b0001 << d;
        return {~one, hex7(disp.data[4*d +: 4]), ~disp.dpm[d]};
    endfunction

    // One clock: sample ack for the current cycle, update the scoreboard,
    // advance past the edge and the frame position.
    task automatic tick(output logic a_obs, output logic a_exp);
        buf_t b;
        #1;
        a_obs = ack;
        if (!rst && load) begin
            b = {data_in, dp_in, en_mask};
            if (sb.size() == 0) sb.push_back(b);
            else sb[0] = b;
        end
        a_exp = !rst && (pos == 18) && (sb.size() > 0);
        if (a_exp) disp = sb.pop_front();
        @(posedge clk);
        #1;
        if (rst) begin
            pos  = 19;
            sb.delete();
            disp = '0;
        end else begin
            pos = (pos + 1) % FRAME;
        end
    endtask

    task automatic test_reset();
        logic a, e;
        rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; en_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({an, segs, dp, ack} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_vals got an=%h segs=%b dp=%b ack=%b exp an=f segs=1111111 dp=1 ack=0", an, segs, dp, ack);
        end
        rst = 1'b0; pos = 19; disp = '0; sb.delete();
        for (int i = 0; i < FRAME; i++) begin
            tick(a, e);
            tests++;
            if (a !== 1'b0) begin fails++; $display("FAIL idle_ack i=%0d got=%b exp=0", i, a); end
            tests++;
            if ({an, segs} !== {4'hF, 7'h7F}) begin
                fails++; $display("FAIL idle_dark i=%0d got an=%h segs=%b exp an=f segs=1111111", i, an, segs);
            end
        end
    endtask

    task automatic test_load();
        logic a, e;
        int acks = 0;
        logic [3:0] an_x[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] sg_x[4] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110};
        for (int i = 0; i < 2*FRAME; i++) begin
            load = (i == 3); data_in = 16'h3210; dp_in = 4'h0; en_mask = 4'hF;
            tick(a, e);
            load = 1'b0;
            if (a === 1'b1) acks++;
            tests++;
            if (a !== e) begin fails++; $display("FAIL load_ack i=%0d got=%b exp=%b", i, a, e); end
            tests++;
            if ({an, segs, dp} !== exp_out()) begin
                fails++; $display("FAIL load_disp pos=%0d got %h exp %h", pos, {an, segs, dp}, exp_out());
            end
            if (i == 19) begin
                tests++;
                if (a !== 1'b1) begin fails++; $display("FAIL load_ack_at_commit got=%b exp=1", a); end
            end
            if (i >= 20 && (i - 20) % 5 == 0) begin
                tests++;
                if ({an, segs} !== {an_x[(i-20)/5], sg_x[(i-20)/5]}) begin
                    fails++; $display("FAIL load_digit d=%0d got an=%h segs=%b exp an=%h segs=%b",
                                      (i-20)/5, an, segs, an_x[(i-20)/5], sg_x[(i-20)/5]);
                end
            end
        end
        tests++;
        if (acks != 1) begin fails++; $display("FAIL load_ack_count got=%0d exp=1", acks); end
    endtask

    task automatic test_back_to_back();
        logic a, e;
        int acks = 0;
        logic [6:0] sg_x[4] = '{7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        for (int i = 0; i < 2*FRAME; i++) begin
            load = (i == 1 || i == 10);
            data_in = (i == 1) ? 16'hAAAA : 16'hFEDC; dp_in = 4'h0; en_mask = 4'hF;
            tick(a, e);
            load = 1'b0;
            if (a === 1'b1) acks++;
            tests++;
            if (a !== e) begin fails++; $display("FAIL b2b_ack i=%0d got=%b exp=%b", i, a, e); end
            tests++;
            if ({an, segs, dp} !== exp_out()) begin
                fails++; $display("FAIL b2b_disp pos=%0d got %h exp %h", pos, {an, segs, dp}, exp_out());
            end
            if (i >= 20 && (i - 20) % 5 == 0) begin
                tests++;
                if (segs !== sg_x[(i-20)/5]) begin
                    fails++; $display("FAIL b2b_digit d=%0d got=%b exp=%b", (i-20)/5, segs, sg_x[(i-20)/5]);
                end
            end
        end
        tests++;
        if (acks != 1) begin fails++; $display("FAIL b2b_ack_count got=%0d exp=1", acks); end
    endtask

    task automatic test_commit_load();
        logic a, e;
        int acks = 0;
        for (int i = 0; i < 3*FRAME; i++) begin
            load = (i == 19); data_in = 16'h5555; dp_in = 4'h0; en_mask = 4'hF;
            tick(a, e);
            load = 1'b0;
            if (a === 1'b1) acks++;
            tests++;
            if (a !== e) begin fails++; $display("FAIL cl_ack i=%0d got=%b exp=%b", i, a, e); end
            tests++;
            if ({an, segs, dp} !== exp_out()) begin
                fails++; $display("FAIL cl_disp pos=%0d got %h exp %h", pos, {an, segs, dp}, exp_out());
            end
            if (i == 19) begin
                tests++;
                if (a !== 1'b1) begin fails++; $display("FAIL cl_ack_same_cycle got=%b exp=1", a); end
            end
            if (i >= 20 && i < 40 && (i - 20) % 5 == 0) begin
                tests++;
                if (segs !== 7'b0100100) begin
                    fails++; $display("FAIL cl_digit i=%0d got=%b exp=0100100", i, segs);
                end
            end
        end
        // a pend flag left set would produce a second ack in the following frame
        tests++;
        if (acks != 1) begin fails++; $display("FAIL cl_ack_count got=%0d exp=1", acks); end
    endtask

    task automatic test_mask();
        logic a, e;
        int lit = 0, dp0 = 0, dp_bad = 0;
        for (int i = 0; i < 2*FRAME; i++) begin
            load = (i == 1); data_in = 16'h3210; dp_in = 4'b0001; en_mask = 4'b0101;
            tick(a, e);
            load = 1'b0;
            tests++;
            if (a !== e) begin fails++; $display("FAIL mask_ack i=%0d got=%b exp=%b", i, a, e); end
            tests++;
            if ({an, segs, dp} !== exp_out()) begin
                fails++; $display("FAIL mask_disp pos=%0d got %h exp %h", pos, {an, segs, dp}, exp_out());
            end
            if (i >= 20) begin
                if (an !== 4'hF) lit++;
                if (dp === 1'b0) begin
                    dp0++;
                    if (an !== 4'hE) dp_bad++;
                end
            end
        end
        tests++;
        if (lit != 8) begin fails++; $display("FAIL mask_lit_cycles got=%0d exp=8", lit); end
        tests++;
        if (dp0 != 4 || dp_bad != 0) begin
            fails++; $display("FAIL mask_dp got=%0d low (%0d off digit 0) exp=4 (0)", dp0, dp_bad);
        end
    endtask

    task automatic test_rst_mid();
        logic a, e;
        int acks;
        for (int i = 0; i <= 12; i++) begin
            load = (i == 5); data_in = 16'h9999; dp_in = 4'h0; en_mask = 4'hF;
            tick(a, e);
            load = 1'b0;
            tests++;
            if ({a, an, segs, dp} !== {e, exp_out()}) begin
                fails++; $display("FAIL rst_pre pos=%0d got %h exp %h", pos, {a, an, segs, dp}, {e, exp_out()});
            end
        end
        tests++;
        if (an !== 4'hB) begin fails++; $display("FAIL rst_pre_digit2 got an=%h exp=b", an); end
        rst = 1'b1;
        tick(a, e);
        rst = 1'b0;
        tests++;
        if ({an, segs, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            fails++; $display("FAIL rst_mid got an=%h segs=%b dp=%b exp an=f segs=1111111 dp=1", an, segs, dp);
        end
        for (int k = 0; k < 2; k++) begin
            acks = 0;
            for (int i = 0; i < 2*FRAME; i++) begin
                load = (k == 1 && i == 1); data_in = 16'h8421; dp_in = 4'h0; en_mask = 4'hF;
                tick(a, e);
                load = 1'b0;
                if (a === 1'b1) acks++;
                tests++;
                if (a !== e) begin fails++; $display("FAIL rst_post_ack k=%0d i=%0d got=%b exp=%b", k, i, a, e); end
                tests++;
                if ({an, segs, dp} !== exp_out()) begin
                    fails++; $display("FAIL rst_post_disp k=%0d pos=%0d got %h exp %h", k, pos, {an, segs, dp}, exp_out());
                end
                if (k == 0) begin
                    tests++;
                    if (an !== 4'hF) begin fails++; $display("FAIL rst_dark i=%0d got an=%h exp=f", i, an); end
                end
            end
            tests++;
            if (acks != k) begin fails++; $display("FAIL rst_ack_count k=%0d got=%0d exp=%0d", k, acks, k); end
        end
    endtask

    initial begin
        pos = 19;
        disp = '0;
        test_reset();
        test_load();
        test_back_to_back();
        test_commit_load();
        test_mask();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
